// File: rtl/operand_fetch.sv
// Operand-fetch stage: a register file with write-back bypass, a load-use hazard
// bubble, and registered outputs that feed the execute stage.
module operand_fetch #(
    parameter int W_OPR  = 32,
    parameter int W_RD   = 5,
    parameter int ADDR   = 32,
    parameter int W_IMM  = 16,
    parameter int D_INFO = 16,
    parameter int WRSV   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    input  logic [ADDR-1:0]   pc_i,
    input  logic [W_IMM-1:0]  imm_i,
    input  logic [W_RD-1:0]   rs0_i,
    input  logic [W_RD-1:0]   rs1_i,
    input  logic [W_RD-1:0]   rd_i,
    input  logic [D_INFO-1:0] d_info_i,
    input  logic              stall_i,
    output logic              stall_o,
    input  logic              flush_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_r_i,
    input  logic [W_OPR-1:0]  wb_data_i,
    output logic              v_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic [W_OPR-1:0]  opr0_o,
    output logic [W_OPR-1:0]  opr1_o,
    output logic [D_INFO-1:0] d_info_o,
    output logic [W_RD-1:0]   rd_o
);

    localparam int N_REG = 1 << W_RD;

    logic [W_OPR-1:0]  regs_r [N_REG];
    logic              v_r;
    logic [ADDR-1:0]   pc_r;
    logic [W_IMM-1:0]  imm_r;
    logic [W_OPR-1:0]  opr0_r;
    logic [W_OPR-1:0]  opr1_r;
    logic [D_INFO-1:0] d_info_r;
    logic [W_RD-1:0]   rd_r;

    logic [W_OPR-1:0]  opr0_s;
    logic [W_OPR-1:0]  opr1_s;
    logic              hazard_s;

    // Operand read with same-cycle write-back bypass
    always_comb begin
        opr0_s = regs_r[rs0_i];
        opr1_s = regs_r[rs1_i];
        if (wb_i && (wb_r_i == rs0_i)) begin
            opr0_s = wb_data_i;
        end else begin
            opr0_s = regs_r[rs0_i];
        end
        if (wb_i && (wb_r_i == rs1_i)) begin
            opr1_s = wb_data_i;
        end else begin
            opr1_s = regs_r[rs1_i];
        end
    end

    // Hazard when the instruction in the output registers will write a register we read
    always_comb begin
        hazard_s = v_i & v_r & d_info_r[WRSV] & ((rd_r == rs0_i) | (rd_r == rs1_i));
        stall_o  = stall_i | (hazard_s & ~flush_i);
    end

    // Register file; write-back is independent of stall and flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_i) begin
            regs_r[wb_r_i] <= wb_data_i;
        end
    end

    // Output registers: flush beats stall beats hazard bubble beats load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r      <= 1'b0;
            pc_r     <= '0;
            imm_r    <= '0;
            opr0_r   <= '0;
            opr1_r   <= '0;
            d_info_r <= '0;
            rd_r     <= '0;
        end else if (flush_i) begin
            v_r <= 1'b0;
        end else if (stall_i) begin
            v_r <= v_r;
        end else if (hazard_s) begin
            v_r <= 1'b0;
        end else begin
            v_r      <= v_i;
            pc_r     <= pc_i;
            imm_r    <= imm_i;
            opr0_r   <= opr0_s;
            opr1_r   <= opr1_s;
            d_info_r <= d_info_i;
            rd_r     <= rd_i;
        end
    end

    assign v_o      = v_r;
    assign pc_o     = pc_r;
    assign imm_o    = imm_r;
    assign opr0_o   = opr0_r;
    assign opr1_o   = opr1_r;
    assign d_info_o = d_info_r;
    assign rd_o     = rd_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed vector bench for operand_fetch: a table of per-cycle stimulus with
// hand-computed results, plus a hand-written asynchronous-reset sequence.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        v_i;
    logic [31:0] pc_i;
    logic [15:0] imm_i;
    logic [4:0]  rs0_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rd_i;
    logic [15:0] d_info_i;
    logic        stall_i;
    logic        stall_o;
    logic        flush_i;
    logic        wb_i;
    logic [4:0]  wb_r_i;
    logic [31:0] wb_data_i;
    logic        v_o;
    logic [31:0] pc_o;
    logic [15:0] imm_o;
    logic [31:0] opr0_o;
    logic [31:0] opr1_o;
    logic [15:0] d_info_o;
    logic [4:0]  rd_o;

    int n_cmp;
    int n_bad;

    operand_fetch dut (
        .clk(clk), .reset(reset), .v_i(v_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs0_i(rs0_i), .rs1_i(rs1_i), .rd_i(rd_i), .d_info_i(d_info_i),
        .stall_i(stall_i), .stall_o(stall_o), .flush_i(flush_i),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
        .v_o(v_o), .pc_o(pc_o), .imm_o(imm_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
        .d_info_o(d_info_o), .rd_o(rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs0, rs1, rd;
        logic [15:0] di;
        logic        st, fl, wb;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        e_stall, e_v, chk;
        logic [31:0] e_pc, e_o0, e_o1;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs0, logic [4:0] rs1,
                                logic [4:0] rd, logic [15:0] di, logic st, logic fl, logic wb,
                                logic [4:0] wbr, logic [31:0] wbd, logic es, logic ev,
                                logic ck, logic [31:0] epc, logic [31:0] eo0, logic [31:0] eo1);
        vec_t r;
        r.v = v; r.pc = pc; r.rs0 = rs0; r.rs1 = rs1; r.rd = rd; r.di = di;
        r.st = st; r.fl = fl; r.wb = wb; r.wbr = wbr; r.wbd = wbd;
        r.e_stall = es; r.e_v = ev; r.chk = ck; r.e_pc = epc; r.e_o0 = eo0; r.e_o1 = eo1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        v_i = t.v; pc_i = t.pc; imm_i = t.pc[15:0] ^ 16'hA5A5;
        rs0_i = t.rs0; rs1_i = t.rs1; rd_i = t.rd; d_info_i = t.di;
        stall_i = t.st; flush_i = t.fl; wb_i = t.wb; wb_r_i = t.wbr; wb_data_i = t.wbd;
    endtask

    vec_t vecs [16];
    vec_t tmp;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // d_info bit 0 is the write-back-valid flag (WRSV = 0)
        vecs[0]  = mk(1'b0, 32'h00, 5'd0, 5'd0, 5'd0,  16'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,  32'h0);
        vecs[1]  = mk(1'b0, 32'h00, 5'd0, 5'd0, 5'd0,  16'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,  32'h0);
        vecs[2]  = mk(1'b1, 32'h10, 5'd1, 5'd2, 5'd6,  16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h10, 32'h11, 32'h22);
        vecs[3]  = mk(1'b1, 32'h14, 5'd3, 5'd1, 5'd7,  16'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 1'b1, 1'b1, 32'h14, 32'h55, 32'h11);
        vecs[4]  = mk(1'b1, 32'h18, 5'd2, 5'd3, 5'd4,  16'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h18, 32'h22, 32'h55);
        vecs[5]  = mk(1'b1, 32'h1c, 5'd0, 5'd4, 5'd8,  16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0);
        vecs[6]  = mk(1'b1, 32'h1c, 5'd0, 5'd4, 5'd8,  16'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h99, 1'b0, 1'b1, 1'b1, 32'h1c, 32'h0,  32'h99);
        vecs[7]  = mk(1'b1, 32'h40, 5'd1, 5'd2, 5'd9,  16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h40, 32'h11, 32'h22);
        vecs[8]  = mk(1'b1, 32'h44, 5'd5, 5'd0, 5'd10, 16'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h7,  1'b1, 1'b1, 1'b1, 32'h40, 32'h11, 32'h22);
        vecs[9]  = mk(1'b1, 32'h44, 5'd5, 5'd0, 5'd10, 16'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h40, 32'h11, 32'h22);
        vecs[10] = mk(1'b1, 32'h44, 5'd5, 5'd0, 5'd10, 16'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h40, 32'h11, 32'h22);
        vecs[11] = mk(1'b1, 32'h44, 5'd5, 5'd0, 5'd10, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h44, 32'h7,  32'h0);
        vecs[12] = mk(1'b1, 32'h48, 5'd0, 5'd0, 5'd11, 16'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h48, 32'h0,  32'h0);
        vecs[13] = mk(1'b1, 32'h4c, 5'd11, 5'd0, 5'd12, 16'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0);
        vecs[14] = mk(1'b1, 32'h50, 5'd1, 5'd0, 5'd13, 16'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h50, 32'h11, 32'h0);
        vecs[15] = mk(1'b0, 32'h54, 5'd13, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h54, 32'h0,  32'h0);

        tmp = mk(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(tmp);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_v", {31'd0, v_o}, 32'd0);
        check("reset_pc", pc_o, 32'd0);
        check("reset_opr0", opr0_o, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall_o", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_v_o", i), {31'd0, v_o}, {31'd0, vecs[i].e_v});
            if (vecs[i].chk) begin
                check($sformatf("v%0d_pc_o", i), pc_o, vecs[i].e_pc);
                check($sformatf("v%0d_imm_o", i), {16'd0, imm_o}, {16'd0, vecs[i].e_pc[15:0] ^ 16'hA5A5});
                check($sformatf("v%0d_opr0_o", i), opr0_o, vecs[i].e_o0);
                check($sformatf("v%0d_opr1_o", i), opr1_o, vecs[i].e_o1);
            end
        end

        // Asynchronous reset while a valid instruction reading r5 (=0x7) is in flight
        @(negedge clk);
        tmp = mk(1'b1, 32'h60, 5'd5, 5'd0, 5'd1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(tmp);
        @(posedge clk);
        #1;
        check("pre_rst_v", {31'd0, v_o}, 32'd1);
        check("pre_rst_opr0", opr0_o, 32'h7);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_v", {31'd0, v_o}, 32'd0);
        check("async_rst_pc", pc_o, 32'd0);
        stall_i = 1'b1;
        #1;
        check("rst_stall_pass", {31'd0, stall_o}, 32'd1);
        stall_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_v", {31'd0, v_o}, 32'd0);
        check("rst_stall_low", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_v", {31'd0, v_o}, 32'd1);
        check("post_rst_pc", pc_o, 32'h60);
        check("post_rst_r5", opr0_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter W_OPR, default 32, operand and register data width.
REQ-002 SHALL have parameter W_RD, default 5, register index width (2**W_RD registers).
REQ-003 SHALL have parameter ADDR, default 32, PC width.
REQ-004 SHALL have parameter W_IMM, default 16, immediate width.
REQ-005 SHALL have parameter D_INFO, default 16, decode-info bundle width.
REQ-006 SHALL have parameter WRSV, default 0, bit index of the write-back-valid flag within d_info.
REQ-007 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-008 SHALL have port reset, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have ports v_i (1), pc_i (ADDR), imm_i (W_IMM), rs0_i (W_RD), rs1_i (W_RD), rd_i (W_RD) and d_info_i (D_INFO), all inputs: the decoded instruction from the decode stage.
REQ-010 SHALL have port stall_i, input, 1, backpressure from the execute stage.
REQ-011 SHALL have port stall_o, output, 1, backpressure to the decode stage.
REQ-012 SHALL have port flush_i, input, 1, taken-branch kill from the execute stage.
REQ-013 SHALL have ports wb_i (1), wb_r_i (W_RD) and wb_data_i (W_OPR), all inputs: the write-back bus from the execute stage.
REQ-014 SHALL have ports v_o (1), pc_o (ADDR), imm_o (W_IMM), opr0_o (W_OPR), opr1_o (W_OPR), d_info_o (D_INFO) and rd_o (W_RD), all outputs, registered, feeding the execute stage.

Function
REQ-015 SHALL contain a 2**W_RD x W_OPR register file, written on the clock edge when wb_i=1 (regfile[wb_r_i] <= wb_data_i), independent of stall or flush; all registers are writable.
REQ-016 SHALL read operand k (k=0,1) as: wb_data_i if wb_i=1 and wb_r_i==rsk_i, else regfile[rsk_i].
REQ-017 SHALL assert hazard = v_i & v_o & d_info_o[WRSV] & (rd_o==rs0_i | rd_o==rs1_i), combinationally; compares are made even when an operand is unused (conservative, false stalls allowed).
REQ-018 SHALL drive stall_o = stall_i | (hazard & ~flush_i).
REQ-019 SHALL apply the following priority on each edge: flush_i=1 -> v_o<=0, other outputs don't-care. Else stall_i=1 -> all output registers hold. Else hazard=1 -> v_o<=0 (bubble). Else all output registers load from the inputs, opr0_o/opr1_o take the REQ-016 values, and v_o<=v_i.
REQ-020 SHALL resolve a hazard with exactly one bubble cycle: the producer leaves the output registers, its result then appears on the write-back bus, and REQ-016 bypasses it.
REQ-021 SHALL, while an instruction is held under stall_i, not re-read operands; a write-back to a source register of a held instruction is covered by the downstream hazard, so no refresh is required.
REQ-022 SHALL have a latency of 1 cycle from input acceptance to outputs, with throughput of 1 instruction per cycle absent hazards and stalls.
REQ-023 SHALL treat v_i=0 as a bubble: it propagates v_o<=0 when not stalled and never raises hazard.

Reset
REQ-024 SHALL, on reset low, immediately clear v_o, pc_o, imm_o, opr0_o, opr1_o, d_info_o, rd_o and every register-file entry to 0.
REQ-025 SHALL block register-file writes and output loads while reset is low, and accept the first instruction on the first rising edge after reset is released.
REQ-026 SHALL drive stall_o = stall_i during reset (hazard is 0 because v_o=0).

Verification
REQ-027 Bypass: wb_i=1, wb_r_i=3, wb_data_i=0x55 in the same cycle as v_i=1, rs0_i=3 -> next cycle opr0_o=0x55, v_o=1; a later read of r3 also returns 0x55.
REQ-028 Load-use: instruction A (rd=4, WRSV=1) followed by B (rs1=4) -> after A is latched, stall_o=1 for 1 cycle and v_o=0; then wb of r4=0x99 -> B issues with opr1_o=0x99.
REQ-029 Stall hold: stall_i=1 for 3 cycles with v_o=1, pc_o=0x40 -> outputs unchanged and stall_o=1; the write-back during the stall still updates the register file.
REQ-030 Flush: flush_i=1 together with hazard=1 and stall_i=0 -> stall_o=0, next cycle v_o=0, and the upstream instruction is dropped.
REQ-031 Reset mid-stream: reset low while v_o=1 with regfile r5=0x7 -> v_o=0 asynchronously; after release, a read of r5 returns 0.
